// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register control, imem handshake,
// redirect (trap/jump/branch) handling and single-entry output buffer.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   trap, jr_valid, jr_tgt     trap / absolute jump redirect requests
//   br_valid, br_pc, br_off    taken branch (target = br_pc + br_off)
//   stall                      downstream not ready
//   pc_cur                     current PC from the external PC register
//   pc_jmp, pc_rel, pc_nxt     PC register controls (hold = 1,1,0)
//   imem_req, imem_addr        fetch request and address
//   imem_ack, imem_data        fetch completion and fetched word
//   inst_valid, inst, inst_pc  instruction to downstream
//   flush                      redirect accepted this cycle
module fetch_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap,
  input  logic        jr_valid,
  input  logic [31:0] jr_tgt,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_off,
  input  logic        stall,
  input  logic [31:0] pc_cur,
  output logic        pc_jmp,
  output logic        pc_rel,
  output logic [31:0] pc_nxt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        flush
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;

  logic        redir;
  logic [31:0] tgt;
  logic        accept;

  // Redirects are ignored during reset; trap wins over jump over branch.
  always_comb begin
    redir = !rst && (trap || jr_valid || br_valid);
    if (trap)
      tgt = TRAP_VEC;
    else if (jr_valid)
      tgt = jr_tgt;
    else
      tgt = br_pc + br_off;
  end

  // A completed fetch is kept only when no redirect kills it.
  assign accept = !rst && (state_q == FETCH) && imem_ack && !redir;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = FETCH;
      FETCH: begin
        if (imem_ack)
          state_d = redir ? FETCH : OUT;
        else if (redir)
          state_d = DRAIN;
      end
      OUT: begin
        if (redir || !stall)
          state_d = FETCH;
      end
      DRAIN: begin
        // A redirect here only reloads the PC; the ack still has to land.
        if (imem_ack)
          state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else if (accept) begin
      inst_q    <= imem_data;
      inst_pc_q <= pc_cur;
    end
  end

  always_comb begin
    pc_jmp     = 1'b1;
    pc_rel     = 1'b1;
    pc_nxt     = '0;
    flush      = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = pc_cur;
    inst_valid = 1'b0;
    if (!rst) begin
      imem_req   = (state_q == FETCH);
      inst_valid = (state_q == OUT);
      if (redir) begin
        pc_rel = 1'b0;
        pc_nxt = tgt;
        flush  = 1'b1;
      end else if (accept) begin
        pc_jmp = 1'b0;
      end
    end
  end

  assign inst    = rst ? '0 : inst_q;
  assign inst_pc = rst ? '0 : inst_pc_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, the absolute trap target address.
REQ-002 The block SHALL have port clk  input  1  clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports trap  input  1  (trap redirect request) and jr_valid  input  1  (absolute jump request).
REQ-005 The block SHALL have ports jr_tgt  input  32  (absolute jump target) and br_valid  input  1  (taken-branch request).
REQ-006 The block SHALL have ports br_pc  input  32  (branch instruction address) and br_off  input  32  (branch offset).
REQ-007 The block SHALL have ports stall  input  1  (downstream not ready) and pc_cur  input  32  (current PC from the PC register).
REQ-008 The block SHALL have ports pc_jmp  output  1, pc_rel  output  1 and pc_nxt  output  32, the PC register controls.
REQ-009 The block SHALL have ports imem_req  output  1  (fetch request) and imem_addr  output  32  (fetch address).
REQ-010 The block SHALL have ports imem_ack  input  1  (fetch complete) and imem_data  input  32  (fetched word).
REQ-011 The block SHALL have ports inst_valid  output  1, inst  output  32 and inst_pc  output  32, the instruction to downstream.
REQ-012 The block SHALL have port flush  output  1  (redirect taken this cycle).

Function
REQ-013 The PC register SHALL be driven as follows: pc_jmp=0 advances it by 4; pc_jmp=1 with pc_rel=0 loads pc_nxt; pc_jmp=1 with pc_rel=1 adds pc_nxt.
REQ-014 Hold SHALL be encoded as pc_jmp=1, pc_rel=1, pc_nxt=0, and SHALL be driven in every cycle with no advance and no redirect.
REQ-015 A redirect SHALL be pending when trap, jr_valid or br_valid is 1, with priority trap > jr_valid > br_valid.
REQ-016 Redirect targets SHALL be: trap = TRAP_VEC; jump = jr_tgt; branch = br_pc + br_off, 32-bit modulo with no carry out.
REQ-017 A pending redirect SHALL be accepted in every state in the same cycle: pc_jmp=1, pc_rel=0, pc_nxt=target and flush=1, all combinational; otherwise flush=0.
REQ-018 The FSM SHALL have four states: IDLE, FETCH, OUT and DRAIN.
REQ-019 IDLE: imem_req=0; next state SHALL be FETCH unconditionally, whether or not a redirect is accepted.
REQ-020 FETCH: imem_req=1 and imem_addr=pc_cur, held stable until imem_ack.
REQ-021 FETCH with imem_ack=1 and no redirect: inst<=imem_data, inst_pc<=pc_cur, pc_jmp=0, next state OUT.
REQ-022 FETCH with imem_ack=1 and a redirect: imem_data SHALL be discarded and the next state SHALL be FETCH.
REQ-023 FETCH with imem_ack=0 and a redirect: next state SHALL be DRAIN, since a request is outstanding.
REQ-024 OUT: inst_valid=1 and imem_req=0; stall=0 SHALL mean the instruction is consumed, next state FETCH; stall=1 SHALL keep state OUT with inst and inst_pc stable.
REQ-025 OUT with a redirect: the buffered instruction SHALL be dropped, inst_valid SHALL be 0 from the next cycle, and the next state SHALL be FETCH, regardless of stall.
REQ-026 DRAIN: imem_req=0; on imem_ack the data SHALL be discarded and the next state SHALL be FETCH; a redirect in DRAIN SHALL reload the PC and SHALL NOT change the state.
REQ-027 inst_valid SHALL be 1 only in state OUT, and SHALL be 0 in all other states.
REQ-028 At most one imem request SHALL be outstanding at any time, and an ack outside FETCH/DRAIN SHALL be ignored.

Reset
REQ-029 While rst=1, the block SHALL hold state IDLE with inst_valid=0, inst=0, inst_pc=0 and imem_req=0; flush SHALL be 0 and redirect inputs SHALL be ignored.
REQ-030 While rst=1, the block SHALL drive the hold encoding; the PC register resets itself to 0.
REQ-031 rst asserted mid-fetch or in DRAIN SHALL abandon the outstanding request without waiting for ack, with state IDLE on the next cycle.

Verification
REQ-032 Reset then ack at every FETCH cycle, stall=0 -> imem_addr sequence 0,4,8; inst_valid pulses with inst_pc 0,4,8, one instruction per 2 cycles.
REQ-033 Fetch at 0x10 acked, stall=1 for 3 cycles -> inst_valid held 4 cycles with inst_pc=0x10 and pc_cur=0x14 constant, then FETCH at 0x14.
REQ-034 br_valid with br_pc=0x20 and br_off=0xFFFF_FFF0 while FETCH is waiting -> flush=1, pc_cur=0x10 next cycle, DRAIN; a late ack is discarded and the next fetch is at 0x10.
REQ-035 trap, jr_valid (jr_tgt=0x40) and br_valid in the same cycle -> pc_nxt=0x100 and flush=1.
REQ-036 Redirect in OUT with stall=1, jr_tgt=0x80 -> inst_valid=0 next cycle; the next imem_addr is 0x80.
REQ-037 rst pulsed in DRAIN, then an ack arrives in IDLE -> the ack is ignored and the first fetch after reset is at 0.
